// File: rtl/isa_pkg.sv
// Shared ISA definitions: ALU command encodings, status flag positions, control bundle.
package isa_pkg;

   localparam int unsigned REG_IDX_W = 4;

   typedef enum logic [3:0] {
      ExeAdd = 4'b0000,
      ExeSub = 4'b0010,
      ExeAnd = 4'b0100,
      ExeOrr = 4'b0101,
      ExeNor = 4'b0110, // shared with SBC
      ExeEor = 4'b0111,
      ExeLsl = 4'b1000,
      ExeAsr = 4'b1001,
      ExeLsr = 4'b1010
   } exe_cmd_e;

   // NZCV bit positions within a 4-bit status word
   localparam int unsigned STATUS_N = 3;
   localparam int unsigned STATUS_Z = 2;
   localparam int unsigned STATUS_C = 1;
   localparam int unsigned STATUS_V = 0;

   typedef struct packed {
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
      logic b;
      logic s;
   } ctrl_t;

   // Control bits only survive when the slot carries a real instruction
   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
      return valid ? c : '0;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise step unless already saturated
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with hazard freeze, branch flush and a bubble counter.
module id_exe_reg
   import isa_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 freeze,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic [DATA_W-1:0]    pc_in,
   input  logic [DATA_W-1:0]    val_rn_in,
   input  logic [DATA_W-1:0]    val_rm_in,
   input  logic                 imm_in,
   input  logic [11:0]          shift_operand_in,
   input  logic [23:0]          signed_imm24_in,
   input  logic [REG_IDX_W-1:0] dest_in,
   input  logic [REG_IDX_W-1:0] src1_in,
   input  logic [REG_IDX_W-1:0] src2_in,
   input  logic [3:0]           exe_cmd_in,
   input  logic                 mem_r_en_in,
   input  logic                 mem_w_en_in,
   input  logic                 wb_en_in,
   input  logic                 b_in,
   input  logic                 s_in,
   input  logic [3:0]           status_in,
   output logic                 valid_out,
   output logic [DATA_W-1:0]    pc_out,
   output logic [DATA_W-1:0]    val_rn_out,
   output logic [DATA_W-1:0]    val_rm_out,
   output logic                 imm_out,
   output logic [11:0]          shift_operand_out,
   output logic [23:0]          signed_imm24_out,
   output logic [REG_IDX_W-1:0] dest_out,
   output logic [REG_IDX_W-1:0] src1_out,
   output logic [REG_IDX_W-1:0] src2_out,
   output logic [3:0]           exe_cmd_out,
   output logic                 mem_r_en_out,
   output logic                 mem_w_en_out,
   output logic                 wb_en_out,
   output logic                 b_out,
   output logic                 s_out,
   output logic [3:0]           status_out,
   output logic [CNT_W-1:0]     bubble_cnt
);

   typedef struct packed {
      logic                 valid;
      logic [DATA_W-1:0]    pc;
      logic [DATA_W-1:0]    val_rn;
      logic [DATA_W-1:0]    val_rm;
      logic                 imm;
      logic [11:0]          shift_operand;
      logic [23:0]          signed_imm24;
      logic [REG_IDX_W-1:0] dest;
      logic [REG_IDX_W-1:0] src1;
      logic [REG_IDX_W-1:0] src2;
      logic [3:0]           exe_cmd;
      ctrl_t                ctrl;
      logic [3:0]           status;
   } slot_t;

   slot_t slot_q, slot_d, slot_in;
   ctrl_t ctrl_in;

   assign ctrl_in = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                      b: b_in, s: s_in};

   // Assemble the incoming slot with control gated by valid_in
   always_comb begin
      slot_in               = '0;
      slot_in.valid         = valid_in;
      slot_in.pc            = pc_in;
      slot_in.val_rn        = val_rn_in;
      slot_in.val_rm        = val_rm_in;
      slot_in.imm           = imm_in;
      slot_in.shift_operand = shift_operand_in;
      slot_in.signed_imm24  = signed_imm24_in;
      slot_in.dest          = dest_in;
      slot_in.src1          = src1_in;
      slot_in.src2          = src2_in;
      slot_in.exe_cmd       = exe_cmd_in;
      slot_in.ctrl          = gate_ctrl(ctrl_in, valid_in);
      slot_in.status        = status_in;
   end

   // Next slot: flush inserts an all-zero bubble (ADD, no enables), freeze holds
   always_comb begin
      slot_d = slot_q;
      if (flush) begin
         slot_d = '0;
      end else if (!freeze) begin
         slot_d = slot_in;
      end
   end

   // Pipeline register; reset contents are themselves a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign valid_out         = slot_q.valid;
   assign pc_out            = slot_q.pc;
   assign val_rn_out        = slot_q.val_rn;
   assign val_rm_out        = slot_q.val_rm;
   assign imm_out           = slot_q.imm;
   assign shift_operand_out = slot_q.shift_operand;
   assign signed_imm24_out  = slot_q.signed_imm24;
   assign dest_out          = slot_q.dest;
   assign src1_out          = slot_q.src1;
   assign src2_out          = slot_q.src2;
   assign exe_cmd_out       = slot_q.exe_cmd;
   assign wb_en_out         = slot_q.ctrl.wb_en;
   assign mem_r_en_out      = slot_q.ctrl.mem_r_en;
   assign mem_w_en_out      = slot_q.ctrl.mem_w_en;
   assign b_out             = slot_q.ctrl.b;
   assign s_out             = slot_q.ctrl.s;
   assign status_out        = slot_q.status;

   // Only flushes count as bubbles; invalid loads do not
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (flush),
      .clear_i (1'b0),
      .cnt_o   (bubble_cnt)
   );

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg with immediate-assertion checks.
module tb_id_exe_reg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ALL_W  = 159;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              freeze, flush, valid_in;
   logic [31:0]       pc_in, val_rn_in, val_rm_in;
   logic              imm_in;
   logic [11:0]       shift_operand_in;
   logic [23:0]       signed_imm24_in;
   logic [3:0]        dest_in, src1_in, src2_in, exe_cmd_in;
   logic              mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;
   logic [3:0]        status_in;

   logic              valid_out;
   logic [31:0]       pc_out, val_rn_out, val_rm_out;
   logic              imm_out;
   logic [11:0]       shift_operand_out;
   logic [23:0]       signed_imm24_out;
   logic [3:0]        dest_out, src1_out, src2_out, exe_cmd_out;
   logic              mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
   logic [3:0]        status_out;
   logic [CNT_W-1:0]  bubble_cnt;

   logic [ALL_W-1:0]  all_out;
   logic [ALL_W-1:0]  exp_q[$];
   logic [ALL_W-1:0]  exp_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_exe_reg #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .freeze            (freeze),
      .flush             (flush),
      .valid_in          (valid_in),
      .pc_in             (pc_in),
      .val_rn_in         (val_rn_in),
      .val_rm_in         (val_rm_in),
      .imm_in            (imm_in),
      .shift_operand_in  (shift_operand_in),
      .signed_imm24_in   (signed_imm24_in),
      .dest_in           (dest_in),
      .src1_in           (src1_in),
      .src2_in           (src2_in),
      .exe_cmd_in        (exe_cmd_in),
      .mem_r_en_in       (mem_r_en_in),
      .mem_w_en_in       (mem_w_en_in),
      .wb_en_in          (wb_en_in),
      .b_in              (b_in),
      .s_in              (s_in),
      .status_in         (status_in),
      .valid_out         (valid_out),
      .pc_out            (pc_out),
      .val_rn_out        (val_rn_out),
      .val_rm_out        (val_rm_out),
      .imm_out           (imm_out),
      .shift_operand_out (shift_operand_out),
      .signed_imm24_out  (signed_imm24_out),
      .dest_out          (dest_out),
      .src1_out          (src1_out),
      .src2_out          (src2_out),
      .exe_cmd_out       (exe_cmd_out),
      .mem_r_en_out      (mem_r_en_out),
      .mem_w_en_out      (mem_w_en_out),
      .wb_en_out         (wb_en_out),
      .b_out             (b_out),
      .s_out             (s_out),
      .status_out        (status_out),
      .bubble_cnt        (bubble_cnt)
   );

   assign all_out = {valid_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                     signed_imm24_out, dest_out, src1_out, src2_out, exe_cmd_out,
                     mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, status_out};

   task automatic chk(input string tag, input logic [ALL_W-1:0] obs,
                      input logic [ALL_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected registered image of the current inputs after a plain load
   function automatic logic [ALL_W-1:0] load_image();
      return {valid_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
              signed_imm24_in, dest_in, src1_in, src2_in, exe_cmd_in,
              mem_r_en_in & valid_in, mem_w_en_in & valid_in, wb_en_in & valid_in,
              b_in & valid_in, s_in & valid_in, status_in};
   endfunction

   task automatic clr_inputs();
      freeze = 0; flush = 0; valid_in = 0;
      pc_in = '0; val_rn_in = '0; val_rm_in = '0; imm_in = 0;
      shift_operand_in = '0; signed_imm24_in = '0;
      dest_in = '0; src1_in = '0; src2_in = '0; exe_cmd_in = '0;
      mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; b_in = 0; s_in = 0;
      status_in = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with random inputs: outputs must be zero without any edge
      rst_n = 0;
      clr_inputs();
      valid_in = 1; wb_en_in = 1; b_in = 1; flush = 1'($urandom);
      pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
      exe_cmd_in = 4'($urandom); dest_in = 4'($urandom); status_in = 4'($urandom);
      #2;
      chk("reset_async_all", all_out, '0);
      chk("reset_async_cnt", {155'd0, bubble_cnt}, '0);
      tick();
      chk("reset_edge_all", all_out, '0);

      // Release and load a SUB
      rst_n = 1;
      clr_inputs();
      val_rn_in = 32'h5; val_rm_in = 32'h3; exe_cmd_in = 4'b0010; wb_en_in = 1; valid_in = 1;
      tick();
      chk("load_rn", {127'd0, val_rn_out}, 159'h5);
      chk("load_rm", {127'd0, val_rm_out}, 159'h3);
      chk("load_cmd", {155'd0, exe_cmd_out}, 159'h2);
      chk("load_wb", {158'd0, wb_en_out}, 159'h1);
      chk("load_valid", {158'd0, valid_out}, 159'h1);
      chk("load_cnt", {155'd0, bubble_cnt}, 159'h0);

      // Every field distinct
      clr_inputs();
      valid_in = 1; pc_in = 32'h0000_1004; val_rn_in = 32'hDEAD_BEEF; val_rm_in = 32'h1234_5678;
      imm_in = 1; shift_operand_in = 12'hA5C; signed_imm24_in = 24'hF0_0F0F;
      dest_in = 4'd11; src1_in = 4'd3; src2_in = 4'd12; exe_cmd_in = 4'b0111;
      mem_r_en_in = 1; s_in = 1; status_in = 4'b1010;
      exp_v = {1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 12'hA5C, 24'hF0_0F0F,
               4'd11, 4'd3, 4'd12, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
      tick();
      chk("full_fields", all_out, exp_v);

      // Freeze holds dest for 3 cycles, new value one cycle after release
      clr_inputs();
      valid_in = 1; dest_in = 4'd7;
      tick();
      chk("frz_load", {155'd0, dest_out}, 159'd7);
      freeze = 1; dest_in = 4'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_hold", {155'd0, dest_out}, 159'd7);
      end
      chk("frz_cnt", {155'd0, bubble_cnt}, 159'd0);
      freeze = 0;
      tick();
      chk("frz_release", {155'd0, dest_out}, 159'd2);

      // Flush beats freeze
      clr_inputs();
      valid_in = 1; mem_w_en_in = 1; pc_in = 32'h100; val_rn_in = 32'h77; dest_in = 4'd5;
      freeze = 1; flush = 1;
      tick();
      chk("flush_all", all_out, '0);
      chk("flush_cnt", {155'd0, bubble_cnt}, 159'd1);

      // Invalid slot: control gated, datapath loads, no bubble counted
      clr_inputs();
      wb_en_in = 1; b_in = 1; mem_r_en_in = 1; s_in = 1; dest_in = 4'd9;
      tick();
      chk("inv_wb", {158'd0, wb_en_out}, 159'd0);
      chk("inv_b", {158'd0, b_out}, 159'd0);
      chk("inv_valid", {158'd0, valid_out}, 159'd0);
      chk("inv_ctrl", {155'd0, mem_r_en_out, mem_w_en_out, s_out, 1'b0}, 159'd0);
      chk("inv_dest", {155'd0, dest_out}, 159'd9);
      chk("inv_cnt", {155'd0, bubble_cnt}, 159'd1);

      // Back-to-back stream alternating ADD/ASR
      for (int i = 0; i < 8; i++) begin
         clr_inputs();
         valid_in = 1; wb_en_in = 1'(i & 1); mem_w_en_in = 1'(~i & 1);
         exe_cmd_in = (i % 2 == 0) ? 4'b0000 : 4'b1001;
         pc_in = 32'(i * 4 + 4); val_rn_in = $urandom; val_rm_in = $urandom;
         dest_in = 4'(i); status_in = 4'(15 - i);
         exp_q.push_back(load_image());
         tick();
         exp_v = exp_q.pop_front();
         chk("stream", all_out, exp_v);
      end
      chk("stream_empty", 159'(exp_q.size()), '0);

      // Reset mid-operation clears immediately; first edge after is a normal load
      #2;
      rst_n = 0;
      #1;
      chk("midrst_all", all_out, '0);
      chk("midrst_cnt", {155'd0, bubble_cnt}, 159'd0);
      #1;
      rst_n = 1;
      clr_inputs();
      valid_in = 1; b_in = 1; signed_imm24_in = 24'h80_0001; pc_in = 32'h200;
      tick();
      chk("post_rst_b", {158'd0, b_out}, 159'd1);
      chk("post_rst_off", {135'd0, signed_imm24_out}, 159'h80_0001);
      chk("post_rst_pc", {127'd0, pc_out}, 159'h200);

      // Saturation with 4-bit counter over 20 flushes
      clr_inputs();
      flush = 1; valid_in = 1; wb_en_in = 1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("sat_cnt", {155'd0, bubble_cnt}, (i < 15) ? 159'(i) : 159'd15);
      end
      chk("sat_bubble", all_out, '0);
      flush = 0; freeze = 1;
      tick();
      chk("sat_frz_hold", {155'd0, bubble_cnt}, 159'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case stimulus ever stalls
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the Instruction Decode stage and the Execute stage that holds the ALU.
- Captures decoded operands and control each cycle, and presents them registered to the ALU and the EXE-side logic (branch adder, status update).
- Supports a hazard freeze (hold contents), a branch flush (insert a bubble), and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, operand/PC width
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  hold all contents (hazard stall)
- flush  in  1  replace next contents with a bubble (branch taken)
- valid_in  in  1  ID slot holds a real instruction
- pc_in  in  DATA_W  PC+4 of the ID instruction
- val_rn_in  in  DATA_W  register-file operand 1
- val_rm_in  in  DATA_W  register-file operand 2
- imm_in  in  1  immediate operand flag
- shift_operand_in  in  12  shifter operand field
- signed_imm24_in  in  24  branch offset
- dest_in  in  4  destination register index
- src1_in  in  4  source register 1 index (for forwarding)
- src2_in  in  4  source register 2 index
- exe_cmd_in  in  4  ALU command, same encoding as the ALU
- mem_r_en_in  in  1  load
- mem_w_en_in  in  1  store
- wb_en_in  in  1  register writeback
- b_in  in  1  branch
- s_in  in  1  update status flags
- status_in  in  4  NZCV snapshot for carry-in
- valid_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out, signed_imm24_out, dest_out, src1_out, src2_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, status_out  out  (widths as inputs)  registered copies
- bubble_cnt  out  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- Clocking and reset: all state is rising-edge clk, asynchronous clear on rst_n=0. While rst_n=0 every output is 0, which makes exe_cmd_out=4'b0000 (ADD) with all enables 0, i.e. a harmless bubble.
- Priority per edge: flush > freeze > normal load.
- Normal load (flush=0, freeze=0): every output takes its matching input. Latency is exactly 1 cycle.
- freeze=1, flush=0: every output, including bubble_cnt, holds its value.
- flush=1 (with freeze either value): the edge inserts a bubble.
  - valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out and s_out clear to 0.
  - Datapath fields (pc, vals, indices, exe_cmd, imm fields, status) clear to 0.
  - bubble_cnt increments.
- Control invariant: a control output (wb_en, mem_r_en, mem_w_en, b, s) may be 1 only while valid_out=1. On load the register stores control_in AND valid_in, so valid_in=0 also yields a bubble. A valid_in=0 load with flush=0 does not count as a bubble.
- bubble_cnt:
  - Increments by 1 on each flush edge.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Clears only on reset.
- Reset mid-operation: asynchronous clear applies immediately. The first edge after release behaves as a normal load.
- No combinational input-to-output path.
- Exactly one always block for state. The count logic is its own process inside the module.

Decomposition:
- Shared package (isa_pkg):
  - EXE_CMD encodings: ADD=0000, SUB=0010, AND=0100, ORR=0101, NOR/SBC=0110, EOR=0111, LSL=1000, ASR=1001, LSR=1010.
  - Status bit positions N=3, Z=2, C=1, V=0.
  - Register index width 4.
- Natural sub-module: sat_counter (CNT_W parameter, inc and clear inputs) for bubble_cnt. Everything else stays inline.

Test Plan:
- Reset: drive random inputs with rst_n=0 -> all outputs 0 asynchronously, no clk edge needed. Release, then load val_rn_in=32'h0000_0005, val_rm_in=32'h0000_0003, exe_cmd_in=4'b0010, wb_en_in=1, valid_in=1 -> next cycle the same values appear on outputs with valid_out=1.
- Freeze: load dest_in=4'd7, then freeze=1 for 3 cycles while inputs change to dest_in=4'd2 -> dest_out stays 7 for all 3 cycles; 4'd2 appears 1 cycle after freeze drops.
- Flush with freeze: valid instruction with mem_w_en_in=1, freeze=1 and flush=1 on the same edge -> all outputs 0, bubble_cnt 0->1.
- Invalid slot: valid_in=0, wb_en_in=1, b_in=1 -> wb_en_out=0, b_out=0, valid_out=0, bubble_cnt unchanged.
- Saturation: CNT_W=4, hold flush=1 for 20 cycles -> bubble_cnt reaches 15 and stays 15.
- Back-to-back: streamed instructions alternating exe_cmd 4'b0000/4'b1001, no stalls -> each appears exactly 1 cycle later with no drops or duplicates, checked against a scoreboard.
